// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the programmable sequence detector.
package seq_detect_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 3;

  localparam logic [2:0] DEF_PATTERN = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Serial Mealy matcher: compares the last PAT_W bits (history plus current bit)
// against the pattern, with overlapping matches.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             match_o
);

  localparam int FILL_W = $clog2(PAT_W);

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  win;

  assign win     = {hist_q, bit_i};
  assign match_o = en_i && (fill_q == FILL_W'(PAT_W - 1)) && (win == pattern_i);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en_i) begin
      hist_d = win[PAT_W-2:0];
      if (fill_q != FILL_W'(PAT_W - 1)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-serial sequence detector with valid/ready handshakes and per-word hit count.
// Define SEQDET_CARRY_EN to keep match history across words (stream mode).
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_hit,
  output logic              bit_valid,
  output logic              bit_x,
  output logic              bit_y
);

  localparam int IDX_W = $clog2(DATA_W);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;
  logic                core_clr;

  assign accept    = (state_q == IDLE) && in_valid;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_count = cnt_q;
  assign out_hit   = |cnt_q;
  assign bit_valid = (state_q == SHIFT);
  assign bit_x     = bit_valid & sh_q[DATA_W-1];

`ifdef SEQDET_CARRY_EN
  // History survives across words unless the newly accepted pattern differs.
  assign core_clr = accept && (cfg_pattern != pat_q);
`else
  assign core_clr = accept;
`endif

  seq_match_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .bit_i    (bit_x),
    .en_i     (bit_valid),
    .clr_i    (core_clr),
    .pattern_i(pat_q),
    .match_o  (bit_y)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          pat_d   = cfg_pattern;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(bit_y);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DATA_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      pat_q   <= PAT_W'(DEF_PATTERN);
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed words plus a cycle-level reference model.
module tb_seq_detect_ctrl;

  localparam int DW = 8;
  localparam int PW = 3;
  localparam int CW = 4;
`ifdef SEQDET_CARRY_EN
  localparam int EXP_STRADDLE = 1;
`else
  localparam int EXP_STRADDLE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] cfg_pattern;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          out_hit;
  logic          bit_valid;
  logic          bit_x;
  logic          bit_y;

  int total = 0;
  int bad   = 0;

  seq_detect_ctrl #(
    .DATA_W(DW),
    .PAT_W (PW),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_pattern(cfg_pattern),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_hit    (out_hit),
    .bit_valid  (bit_valid),
    .bit_x      (bit_x),
    .bit_y      (bit_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting, 1..DW = scanning bit phase-1, DW+1 = result held.
  int          m_phase = 0;
  bit          hq[$];
  bit [PW-1:0] m_prev = 3'b101;
  bit [DW-1:0] m_x, m_y;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      hq.delete();
      m_prev  = 3'b101;
    end else if (m_phase == 0) begin
      if (in_valid) begin
`ifdef SEQDET_CARRY_EN
        if (cfg_pattern != m_prev) hq.delete();
`else
        hq.delete();
`endif
        m_prev = cfg_pattern;
        m_cnt  = 0;
        for (int k = 0; k < DW; k++) begin
          bit b, hit;
          b = in_data[DW-1-k];
          hq.push_back(b);
          if (hq.size() > PW) void'(hq.pop_front());
          hit = (hq.size() == PW);
          for (int j = 0; j < PW; j++)
            if (hq.size() == PW && hq[j] != cfg_pattern[PW-1-j]) hit = 1'b0;
          m_x[k] = b;
          m_y[k] = hit;
          m_cnt  = m_cnt + int'(hit);
        end
        m_phase = 1;
      end
    end else if (m_phase <= DW) begin
      m_phase++;
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_bit_valid", bit_valid, 0);
    end else begin
      chk("cmp_in_ready", in_ready, m_phase == 0);
      chk("cmp_out_valid", out_valid, m_phase == DW + 1);
      chk("cmp_bit_valid", bit_valid, (m_phase >= 1) && (m_phase <= DW));
      if (m_phase >= 1 && m_phase <= DW) begin
        chk("cmp_bit_x", bit_x, m_x[m_phase-1]);
        chk("cmp_bit_y", bit_y, m_y[m_phase-1]);
      end
      if (m_phase == DW + 1) begin
        chk("cmp_out_count", out_count, m_cnt);
        chk("cmp_out_hit", out_hit, m_cnt != 0);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p);
    int n = 0;
    in_data     = d;
    cfg_pattern = p;
    in_valid    = 1'b1;
    while (!in_ready && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_cnt, input bit chk_lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    if (chk_lat) chk({name, "_latency"}, n, DW);
    chk({name, "_count"}, out_count, exp_cnt);
    chk({name, "_hit"}, out_hit, exp_cnt != 0);
    if (out_ready) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    cfg_pattern = 3'b101;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_count", out_count, 0);
    chk("reset_bits", {bit_valid, bit_x, bit_y, out_hit}, 0);
    rst = 1'b1;
    @(posedge clk); #2;

    send(8'b10101010, 3'b101);
    wait_result("alt101", 3, 1'b1);

    send(8'hFF, 3'b111);
    wait_result("ones111", 6, 1'b1);
    send(8'h00, 3'b111);
    wait_result("zeros111", 0, 1'b0);

    send(8'b00000010, 3'b101);
    wait_result("straddle_a", 0, 1'b0);
    send(8'b10000000, 3'b101);
    wait_result("straddle_b", EXP_STRADDLE, 1'b0);

    // Backpressure with a word waiting on the input side.
    out_ready = 1'b0;
    send(8'hA5, 3'b101);
    wait_result("bp", 2, 1'b1);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_count", out_count, 2);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_after_hs_in_ready", in_ready, 1);
    chk("bp_after_hs_out_valid", out_valid, 0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("bp_pending_taken", in_ready, 0);
    wait_result("bp_next", 3, 1'b1);

    // Reset during the fourth serial bit.
    send(8'hFF, 3'b101);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_bit_valid", bit_valid, 1);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_outs", {out_valid, out_hit, bit_valid, bit_x, bit_y}, 0);
    chk("midrst_count", out_count, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    send(8'b10100000, 3'b101);
    wait_result("post_rst", 1, 1'b1);

    // Pattern change while a word is being scanned.
    send(8'b10100000, 3'b101);
    repeat (2) @(posedge clk);
    #2;
    cfg_pattern = 3'b011;
    wait_result("cfg_cur", 1, 1'b0);
    send(8'b01100000, 3'b011);
    wait_result("cfg_next", 1, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

- Sequences parallel words through a bit-serial, programmable-pattern Mealy sequence detector and returns a per-word hit count.
- Sits between a word producer and a result consumer. Both sides use valid/ready handshakes.
- Generalises the fixed "101" detector in the FSM library:
  - the pattern is runtime-configurable;
  - matches may overlap;
  - the block owns input scheduling and result buffering.

## Interface
Parameters:
- DATA_W, default 8: bits per input word; serialised MSB first.
- PAT_W, default 3: pattern length; legal range 2..DATA_W.
- CNT_W, default $clog2(DATA_W+1): width of the hit count.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- cfg_pattern  input  PAT_W  pattern; MSB is matched first; sampled only on input accept.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_W  word to scan.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_count  output  CNT_W  number of pattern hits in the word.
- out_hit  output  1  out_count != 0.
- bit_valid  output  1  a serial bit is being scanned this cycle.
- bit_x  output  1  current serial bit.
- bit_y  output  1  Mealy match flag for the current bit (combinational from bit_x and history).

## Operation
- State machine, states IDLE, SHIFT, DONE; reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data into the shift register and cfg_pattern into the pattern register.
  - Clear the bit index and hit counter, then go to SHIFT.
- SHIFT:
  - One bit per cycle, MSB first; bit_valid = 1.
  - history <= {history[PAT_W-2:0], bit_x}.
  - bit_y = 1 when fill + 1 >= PAT_W and {history[PAT_W-2:0], bit_x} == pattern.
  - The counter increments on each bit_y.
  - Matches overlap: the history is not cleared on a hit.
  - After bit DATA_W-1, go to DONE.
- DONE:
  - out_valid = 1; out_count and out_hit are held stable.
  - On out_ready, go to IDLE.
- Fill counter: tracks valid history bits and saturates at PAT_W-1.
- History handling between words depends on the configuration macro (see Configuration).
- The count cannot overflow: the maximum is DATA_W and CNT_W covers it.
- cfg_pattern changes outside IDLE accept have no effect on the word in flight.

## Timing
- Reset values: in_ready=1, out_valid=0, out_count=0, out_hit=0, bit_valid=0, bit_x=0, bit_y=0. History, fill, counter and index are cleared.
- Latency from accept to result:
  - accept in cycle 0;
  - bits in cycles 1..DATA_W;
  - out_valid rises in cycle DATA_W+1.
- Throughput: one word per DATA_W+2 cycles when out_ready is held high.
- in_ready is low from the accept edge until the cycle after the DONE handshake. There is no input/output overlap (single-word buffer).
- out_valid, once high, stays high with stable data until out_ready is sampled high. in_valid may drop at any time without effect.
- Reset asserted mid-SHIFT or mid-DONE:
  - all outputs take reset values immediately (asynchronous);
  - the in-flight word and its partial count are discarded.

## Configuration
- Macro: SEQDET_CARRY_EN.
- Defined (stream mode):
  - history and fill persist across words;
  - a pattern may straddle the word boundary, and the hit is counted in the later word;
  - history and fill are cleared only by reset, or when the accepted cfg_pattern differs from the previous pattern.
- Undefined (word mode): history and fill are cleared on every input accept; each word is scanned independently.

## Structure
- Shared package seq_detect_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - default parameter constants;
  - the default pattern 3'b101.
- Sub-module seq_match_core: a pure serial Mealy matcher.
  - Inputs: bit, enable, clear, pattern.
  - Outputs: match.
  - Holds history and fill.
- seq_detect_ctrl owns the handshakes, the shift register, the bit index and the hit counter.

## Test plan
- Word mode, pattern 3'b101, in_data 8'b10101010 → out_count=3, out_hit=1; out_valid rises exactly 9 cycles after accept.
- Pattern 3'b111, in_data 8'hFF → out_count=6 (overlap). Then in_data 8'h00 → out_count=0, out_hit=0.
- Words 8'b00000010 then 8'b10000000, pattern 3'b101:
  - with SEQDET_CARRY_EN, second word → out_count=1;
  - without, second word → out_count=0.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid held, out_count stable, in_ready=0; a pending in_valid is not accepted until the cycle after the handshake.
- Reset pulse (rst=0) during the 4th SHIFT bit → all outputs 0 and in_ready=1 during reset; the next word 8'b10100000 with pattern 3'b101 → out_count=1 (no residual history).
- cfg_pattern changed to 3'b011 mid-SHIFT → the current word still uses 3'b101; the next accepted word uses 3'b011.
